// File: rtl/gemm_pkg.sv
// Shared types and elaboration-time helpers for the GEMM engine.
package gemm_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WAIT,
    WR,
    DONE
  } gemm_state_e;

  // Default bus width and the byte stride of one beat at that width.
  localparam int unsigned GEMM_DEF_BUS_W       = 128;
  localparam int unsigned GEMM_DEF_BEAT_STRIDE = GEMM_DEF_BUS_W / 8;

  // One beat must carry a whole input matrix and a whole output row.
  function automatic bit gemm_params_legal(input int unsigned dim,
                                           input int unsigned elem_w,
                                           input int unsigned acc_w,
                                           input int unsigned bus_w);
    return (dim > 0) && (dim * dim * elem_w == bus_w) && (dim * acc_w == bus_w);
  endfunction

  // Byte distance between consecutive beats in memory.
  function automatic int unsigned gemm_beat_stride(input int unsigned bus_w);
    return bus_w / 8;
  endfunction

endpackage

// File: rtl/gemm_row_mac.sv
// One output row: DIM signed dot products of an A row against B columns, plus a bias row.
module gemm_row_mac
  import gemm_pkg::*;
#(
  parameter int unsigned DIM    = 4,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic [DIM*ELEM_W-1:0]     a_row,
  input  logic [DIM*DIM*ELEM_W-1:0] b_mat,
  input  logic [DIM*ACC_W-1:0]      bias_row,
  output logic [DIM*ACC_W-1:0]      row_sum_c
);

  logic signed [ACC_W-1:0]    sum;
  logic signed [ELEM_W-1:0]   a_e;
  logic signed [ELEM_W-1:0]   b_e;
  logic signed [2*ELEM_W-1:0] prod;

  // Column-wise signed multiply-accumulate, wrapping at ACC_W bits.
  always_comb begin
    row_sum_c = '0;
    sum       = '0;
    a_e       = '0;
    b_e       = '0;
    prod      = '0;
    for (int c = 0; c < int'(DIM); c++) begin
      sum = bias_row[c*ACC_W +: ACC_W];
      for (int i = 0; i < int'(DIM); i++) begin
        a_e  = a_row[i*ELEM_W +: ELEM_W];
        b_e  = b_mat[(i*DIM+c)*ELEM_W +: ELEM_W];
        prod = a_e * b_e;
        sum  = sum + ACC_W'(prod);
      end
      row_sum_c[c*ACC_W +: ACC_W] = sum;
    end
  end

endmodule

// File: rtl/gemm_engine.sv
// Matrix-multiply engine: fetches A/B pairs as single beats, writes C one row per beat.
module gemm_engine
  import gemm_pkg::*;
#(
  parameter int unsigned DIM    = 4,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned BUS_W  = 128,
  parameter int unsigned MCNT_W = 8,
  parameter logic [31:0] A_BASE = 32'h0000_0000,
  parameter logic [31:0] B_BASE = 32'h0001_0000,
  parameter logic [31:0] C_BASE = 32'h0002_0000
) (
  input  logic              vsi_clk,
  input  logic              vsi_reset_n,
  input  logic              vsi_start,
  input  logic [MCNT_W-1:0] vsi_matrix_cnt,
  input  logic              vsi_acc_mode,
  output logic              vsi_done,
  output logic              vsi_raddr_valid,
  output logic [31:0]       vsi_raddr,
  input  logic              vsi_rdata_valid,
  input  logic [BUS_W-1:0]  vsi_rdata,
  output logic              vsi_wx_valid,
  output logic [31:0]       vsi_waddr,
  output logic [BUS_W-1:0]  vsi_wdata,
  output logic [BUS_W/8-1:0] vsi_wstrobe
);

  localparam int unsigned STRIDE = gemm_beat_stride(BUS_W);
  localparam int unsigned ROW_W  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned MAT_W  = DIM * DIM * ELEM_W;
  localparam int unsigned ROWA_W = DIM * ELEM_W;
  localparam int unsigned ROWC_W = DIM * ACC_W;
  localparam int unsigned STRB_W = BUS_W / 8;

  // Reject parameter sets where a beat cannot hold a matrix or a result row.
  if (!gemm_params_legal(DIM, ELEM_W, ACC_W, BUS_W)) begin : g_bad_params
    $error("gemm_engine: illegal DIM/ELEM_W/ACC_W/BUS_W combination");
  end

  gemm_state_e         state_q, state_d;
  logic [MCNT_W-1:0]   cnt_q, cnt_d;
  logic                acc_mode_q, acc_mode_d;
  logic [MCNT_W-1:0]   k_q, k_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [MAT_W-1:0]    a_q, a_d;
  logic [MAT_W-1:0]    b_q, b_d;
  logic                a_held_q, a_held_d;
  logic                b_held_q, b_held_d;
  logic [ROWC_W-1:0]   acc_q [DIM];
  logic [ROWC_W-1:0]   acc_d [DIM];

  logic                raddr_valid_q, raddr_valid_d;
  logic [31:0]         raddr_q, raddr_d;
  logic                wx_valid_q, wx_valid_d;
  logic [31:0]         waddr_q, waddr_d;
  logic [BUS_W-1:0]    wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrobe_q, wstrobe_d;
  logic                done_q, done_d;

  logic [ROWA_W-1:0]   a_rows [DIM];
  logic [ROWC_W-1:0]   mac_row_c;
  logic                last_c;
  logic [MCNT_W-1:0]   c_pair_c;

  // Split the held A beat into rows for the row selector.
  for (genvar g = 0; g < int'(DIM); g++) begin : g_rows
    assign a_rows[g] = a_q[g*ROWA_W +: ROWA_W];
  end

  assign last_c   = (k_q == cnt_q - MCNT_W'(1));
  assign c_pair_c = acc_mode_q ? '0 : k_q;

  gemm_row_mac #(
    .DIM    (DIM),
    .ELEM_W (ELEM_W),
    .ACC_W  (ACC_W)
  ) u_row_mac (
    .a_row     (a_rows[row_q]),
    .b_mat     (b_q),
    .bias_row  (acc_q[row_q]),
    .row_sum_c (mac_row_c)
  );

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    acc_mode_d    = acc_mode_q;
    k_d           = k_q;
    row_d         = row_q;
    a_d           = a_q;
    b_d           = b_q;
    a_held_d      = a_held_q;
    b_held_d      = b_held_q;
    acc_d         = acc_q;
    raddr_valid_d = 1'b0;
    raddr_d       = '0;
    wx_valid_d    = 1'b0;
    waddr_d       = '0;
    wdata_d       = '0;
    wstrobe_d     = '0;
    done_d        = (state_q == DONE);

    // Returned beats fill A first, then B; idle-time beats are dropped.
    if (vsi_rdata_valid && (state_q != IDLE) && (state_q != DONE)) begin
      if (!a_held_q) begin
        a_d      = vsi_rdata;
        a_held_d = 1'b1;
      end else if (!b_held_q) begin
        b_d      = vsi_rdata;
        b_held_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        k_d      = '0;
        row_d    = '0;
        a_held_d = 1'b0;
        b_held_d = 1'b0;
        for (int i = 0; i < int'(DIM); i++) acc_d[i] = '0;
        if (vsi_start) begin
          cnt_d      = vsi_matrix_cnt;
          acc_mode_d = vsi_acc_mode;
          state_d    = (vsi_matrix_cnt == '0) ? DONE : RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: state_d = WAIT;
      WAIT: begin
        if (a_held_q && b_held_q) begin
          if (acc_mode_q && !last_c) begin
            // Fold this pair into the accumulator one row per cycle.
            acc_d[row_q] = mac_row_c;
            if (row_q == ROW_W'(DIM - 1)) begin
              row_d    = '0;
              k_d      = k_q + MCNT_W'(1);
              a_held_d = 1'b0;
              b_held_d = 1'b0;
              state_d  = RD_A;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            row_d   = '0;
            state_d = WR;
          end
        end
      end
      WR: begin
        wx_valid_d = 1'b1;
        wdata_d    = mac_row_c;
        wstrobe_d  = '1;
        waddr_d    = C_BASE + (32'(c_pair_c) * 32'(DIM) + 32'(row_q)) * 32'(STRIDE);
        if (row_q == ROW_W'(DIM - 1)) begin
          row_d = '0;
          if (last_c) begin
            state_d = DONE;
          end else begin
            k_d      = k_q + MCNT_W'(1);
            a_held_d = 1'b0;
            b_held_d = 1'b0;
            state_d  = RD_A;
          end
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Read requests are presented for exactly the RD_A and RD_B cycles.
    if (state_d == RD_A) begin
      raddr_valid_d = 1'b1;
      raddr_d       = A_BASE + 32'(k_d) * 32'(STRIDE);
    end else if (state_d == RD_B) begin
      raddr_valid_d = 1'b1;
      raddr_d       = B_BASE + 32'(k_d) * 32'(STRIDE);
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      acc_mode_q    <= 1'b0;
      k_q           <= '0;
      row_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      a_held_q      <= 1'b0;
      b_held_q      <= 1'b0;
      for (int i = 0; i < int'(DIM); i++) acc_q[i] <= '0;
      raddr_valid_q <= 1'b0;
      raddr_q       <= '0;
      wx_valid_q    <= 1'b0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wstrobe_q     <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      acc_mode_q    <= acc_mode_d;
      k_q           <= k_d;
      row_q         <= row_d;
      a_q           <= a_d;
      b_q           <= b_d;
      a_held_q      <= a_held_d;
      b_held_q      <= b_held_d;
      acc_q         <= acc_d;
      raddr_valid_q <= raddr_valid_d;
      raddr_q       <= raddr_d;
      wx_valid_q    <= wx_valid_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
      wstrobe_q     <= wstrobe_d;
      done_q        <= done_d;
    end
  end

  assign vsi_raddr_valid = raddr_valid_q;
  assign vsi_raddr       = raddr_q;
  assign vsi_wx_valid    = wx_valid_q;
  assign vsi_waddr       = waddr_q;
  assign vsi_wdata       = wdata_q;
  assign vsi_wstrobe     = wstrobe_q;
  assign vsi_done        = done_q;

endmodule

// File: tb/tb_gemm_engine.sv
// Self-checking bench for gemm_engine with a memory responder and a matrix-level model.
module tb_gemm_engine;

  localparam logic [31:0] A_BASE = 32'h0000_0000;
  localparam logic [31:0] B_BASE = 32'h0001_0000;
  localparam logic [31:0] C_BASE = 32'h0002_0000;

  logic         vsi_clk = 1'b0;
  logic         vsi_reset_n;
  logic         vsi_start;
  logic [7:0]   vsi_matrix_cnt;
  logic         vsi_acc_mode;
  logic         vsi_done;
  logic         vsi_raddr_valid;
  logic [31:0]  vsi_raddr;
  logic         vsi_rdata_valid;
  logic [127:0] vsi_rdata;
  logic         vsi_wx_valid;
  logic [31:0]  vsi_waddr;
  logic [127:0] vsi_wdata;
  logic [15:0]  vsi_wstrobe;

  gemm_engine dut (
    .vsi_clk         (vsi_clk),
    .vsi_reset_n     (vsi_reset_n),
    .vsi_start       (vsi_start),
    .vsi_matrix_cnt  (vsi_matrix_cnt),
    .vsi_acc_mode    (vsi_acc_mode),
    .vsi_done        (vsi_done),
    .vsi_raddr_valid (vsi_raddr_valid),
    .vsi_raddr       (vsi_raddr),
    .vsi_rdata_valid (vsi_rdata_valid),
    .vsi_rdata       (vsi_rdata),
    .vsi_wx_valid    (vsi_wx_valid),
    .vsi_waddr       (vsi_waddr),
    .vsi_wdata       (vsi_wdata),
    .vsi_wstrobe     (vsi_wstrobe)
  );

  always #5 vsi_clk = ~vsi_clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rd_t;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } wr_t;

  int n_checks;
  int n_fail;
  int cyc;
  int lat;
  int n_reads;
  int n_done;
  rd_t rd_q[$];
  wr_t wr_q[$];
  logic [127:0] mem [int unsigned];
  int a_m [8][16];
  int b_m [8][16];
  int exp_c [8][16];

  // Memory responder plus write/done monitor, all sampled 1 time unit after the edge.
  initial begin
    vsi_rdata_valid = 1'b0;
    vsi_rdata       = '0;
    cyc             = 0;
    forever begin
      @(posedge vsi_clk);
      #1;
      cyc++;
      if (vsi_raddr_valid === 1'b1) begin
        rd_q.push_back('{vsi_raddr, cyc + lat});
        n_reads++;
      end
      if (vsi_wx_valid === 1'b1) wr_q.push_back('{vsi_waddr, vsi_wdata, vsi_wstrobe});
      if (vsi_done === 1'b1) n_done++;
      vsi_rdata_valid = 1'b0;
      vsi_rdata       = {$urandom, $urandom, $urandom, $urandom};
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        rd_t r;
        r = rd_q.pop_front();
        vsi_rdata_valid = 1'b1;
        vsi_rdata       = mem.exists(r.addr) ? mem[r.addr] : '0;
      end
    end
  end

  function automatic logic [127:0] pack_mat(input bit is_b, input int k);
    logic [127:0] v;
    v = '0;
    for (int e = 0; e < 16; e++) v[e*8 +: 8] = is_b ? 8'(b_m[k][e]) : 8'(a_m[k][e]);
    return v;
  endfunction

  // Plain matrix product, summed into slot 0 when accumulating.
  function automatic void model(input int cnt, input bit mode);
    for (int p = 0; p < 8; p++) for (int e = 0; e < 16; e++) exp_c[p][e] = 0;
    for (int k = 0; k < cnt; k++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          int s;
          s = 0;
          for (int i = 0; i < 4; i++) s += a_m[k][r*4+i] * b_m[k][i*4+c];
          exp_c[mode ? 0 : k][r*4+c] += s;
        end
      end
    end
  endfunction

  function automatic logic [127:0] exp_row(input int p, input int r);
    logic [127:0] v;
    for (int c = 0; c < 4; c++) v[c*32 +: 32] = 32'(exp_c[p][r*4+c]);
    return v;
  endfunction

  function automatic void load_mem(input int cnt);
    mem.delete();
    for (int k = 0; k < cnt; k++) begin
      mem[A_BASE + 32'(k*16)] = pack_mat(1'b0, k);
      mem[B_BASE + 32'(k*16)] = pack_mat(1'b1, k);
    end
  endfunction

  function automatic void fill_identity(input int k);
    for (int e = 0; e < 16; e++) begin
      a_m[k][e] = (e / 4 == e % 4) ? 1 : 0;
      b_m[k][e] = (e / 4 == e % 4) ? 1 : 0;
    end
  endfunction

  function automatic void fill_random(input int k);
    for (int e = 0; e < 16; e++) begin
      a_m[k][e] = int'($urandom_range(0, 255)) - 128;
      b_m[k][e] = int'($urandom_range(0, 255)) - 128;
    end
  endfunction

  task automatic start_job(input int cnt, input bit mode, input int l);
    lat     = l;
    n_reads = 0;
    n_done  = 0;
    wr_q.delete();
    rd_q.delete();
    load_mem(cnt);
    vsi_matrix_cnt = 8'(cnt);
    vsi_acc_mode   = mode;
    vsi_start      = 1'b1;
    @(posedge vsi_clk);
    #1;
    vsi_start = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    int t;
    t = 0;
    while (vsi_done !== 1'b1 && t < 3000) begin
      @(posedge vsi_clk);
      #1;
      t++;
    end
    n_checks++;
    if (vsi_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done after %0d cycles, required a done pulse", tag, t);
    end
    repeat (3) begin
      @(posedge vsi_clk);
      #1;
    end
  endtask

  task automatic check_writes(input string tag, input int cnt, input bit mode);
    int n_exp;
    model(cnt, mode);
    n_exp = mode ? 4 : cnt * 4;
    n_checks++;
    if (wr_q.size() != n_exp) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", tag, wr_q.size(), n_exp);
    end
    n_checks++;
    if (n_reads != 2 * cnt) begin
      n_fail++;
      $display("FAIL %s read_count: got %0d required %0d", tag, n_reads, 2 * cnt);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL %s done_count: got %0d required 1", tag, n_done);
    end
    for (int i = 0; i < wr_q.size() && i < n_exp; i++) begin
      logic [31:0] want_addr;
      logic [127:0] want_data;
      want_addr = C_BASE + 32'(i * 16);
      want_data = exp_row(mode ? 0 : i / 4, i % 4);
      n_checks++;
      if (wr_q[i].addr !== want_addr) begin
        n_fail++;
        $display("FAIL %s waddr[%0d]: got %h required %h", tag, i, wr_q[i].addr, want_addr);
      end
      n_checks++;
      if (wr_q[i].data !== want_data) begin
        n_fail++;
        $display("FAIL %s wdata[%0d]: got %h required %h", tag, i, wr_q[i].data, want_data);
      end
      n_checks++;
      if (wr_q[i].strb !== 16'hFFFF) begin
        n_fail++;
        $display("FAIL %s wstrobe[%0d]: got %h required ffff", tag, i, wr_q[i].strb);
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({vsi_raddr_valid, vsi_wx_valid, vsi_done} !== 3'b000) begin
      n_fail++;
      $display("FAIL %s valids: got rv=%b wv=%b done=%b required all 0", tag,
               vsi_raddr_valid, vsi_wx_valid, vsi_done);
    end
    n_checks++;
    if (vsi_raddr !== 32'h0 || vsi_waddr !== 32'h0) begin
      n_fail++;
      $display("FAIL %s addrs: got raddr=%h waddr=%h required 0", tag, vsi_raddr, vsi_waddr);
    end
    n_checks++;
    if (vsi_wdata !== '0 || vsi_wstrobe !== '0) begin
      n_fail++;
      $display("FAIL %s wdata_strb: got %h / %h required 0", tag, vsi_wdata, vsi_wstrobe);
    end
  endtask

  task automatic test_reset();
    vsi_reset_n    = 1'b0;
    vsi_start      = 1'b0;
    vsi_matrix_cnt = '0;
    vsi_acc_mode   = 1'b0;
    repeat (3) @(posedge vsi_clk);
    #1;
    check_outputs_zero("reset_hold");
    vsi_reset_n = 1'b1;
    @(posedge vsi_clk);
    #1;
    check_outputs_zero("reset_release");
  endtask

  task automatic test_identity();
    fill_identity(0);
    for (int e = 0; e < 16; e++) b_m[0][e] = e;
    start_job(1, 1'b0, 1);
    finish_job("identity");
    check_writes("identity", 1, 1'b0);
    for (int r = 0; r < 4 && r < wr_q.size(); r++) begin
      logic [127:0] want;
      want = {32'(r*4+3), 32'(r*4+2), 32'(r*4+1), 32'(r*4)};
      n_checks++;
      if (wr_q[r].data !== want) begin
        n_fail++;
        $display("FAIL identity_row[%0d]: got %h required %h", r, wr_q[r].data, want);
      end
    end
  endtask

  task automatic test_neg128();
    for (int e = 0; e < 16; e++) begin
      a_m[0][e] = -128;
      b_m[0][e] = -128;
    end
    start_job(1, 1'b0, 2);
    finish_job("neg128");
    check_writes("neg128", 1, 1'b0);
    for (int r = 0; r < 4 && r < wr_q.size(); r++) begin
      n_checks++;
      if (wr_q[r].data !== {4{32'd65536}}) begin
        n_fail++;
        $display("FAIL neg128_row[%0d]: got %h required all 00010000", r, wr_q[r].data);
      end
    end
  endtask

  task automatic test_acc_identity();
    for (int k = 0; k < 3; k++) fill_identity(k);
    start_job(3, 1'b1, 1);
    finish_job("acc_identity");
    check_writes("acc_identity", 3, 1'b1);
    for (int r = 0; r < 4 && r < wr_q.size(); r++) begin
      logic [127:0] want;
      want = '0;
      want[r*32 +: 32] = 32'd3;
      n_checks++;
      if (wr_q[r].data !== want) begin
        n_fail++;
        $display("FAIL acc_identity_row[%0d]: got %h required %h", r, wr_q[r].data, want);
      end
    end
  endtask

  task automatic test_cnt_zero();
    start_job(0, 1'b0, 1);
    n_checks++;
    if (vsi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_zero_done_early: got %b required 0 one cycle after start", vsi_done);
    end
    @(posedge vsi_clk);
    #1;
    n_checks++;
    if (vsi_done !== 1'b1) begin
      n_fail++;
      $display("FAIL cnt_zero_done: got %b required 1 two cycles after start", vsi_done);
    end
    @(posedge vsi_clk);
    #1;
    n_checks++;
    if (vsi_done !== 1'b0) begin
      n_fail++;
      $display("FAIL cnt_zero_done_pulse: got %b required 0 after one cycle", vsi_done);
    end
    repeat (3) @(posedge vsi_clk);
    #1;
    n_checks++;
    if (n_reads != 0 || wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL cnt_zero_traffic: got reads=%0d writes=%0d required 0/0", n_reads, wr_q.size());
    end
  endtask

  task automatic test_second_start();
    fill_random(0);
    fill_random(1);
    start_job(2, 1'b0, 5);
    repeat (2) begin
      @(posedge vsi_clk);
      #1;
    end
    vsi_matrix_cnt = 8'd5;
    vsi_acc_mode   = 1'b1;
    vsi_start      = 1'b1;
    @(posedge vsi_clk);
    #1;
    vsi_start = 1'b0;
    finish_job("second_start");
    check_writes("second_start", 2, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int cnt;
      bit mode;
      int l;
      cnt  = int'($urandom_range(1, 4));
      mode = 1'($urandom_range(0, 1));
      l    = int'($urandom_range(1, 6));
      for (int k = 0; k < cnt; k++) fill_random(k);
      start_job(cnt, mode, l);
      finish_job("random");
      check_writes("random", cnt, mode);
    end
  endtask

  task automatic test_reset_mid_wr();
    int t;
    fill_random(0);
    start_job(1, 1'b0, 1);
    t = 0;
    while (vsi_wx_valid !== 1'b1 && t < 200) begin
      @(posedge vsi_clk);
      #1;
      t++;
    end
    n_checks++;
    if (vsi_wx_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_wr_reach: got no write after %0d cycles, required a write", t);
    end
    #2;
    vsi_reset_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_wr");
    @(posedge vsi_clk);
    #1;
    fill_random(0);
    lat     = 2;
    n_reads = 0;
    n_done  = 0;
    wr_q.delete();
    rd_q.delete();
    load_mem(1);
    vsi_matrix_cnt = 8'd1;
    vsi_acc_mode   = 1'b0;
    vsi_start      = 1'b1;
    vsi_reset_n    = 1'b1;
    @(posedge vsi_clk);
    #1;
    vsi_start = 1'b0;
    n_checks++;
    if (vsi_raddr_valid !== 1'b1 || vsi_raddr !== A_BASE) begin
      n_fail++;
      $display("FAIL reset_first_edge_start: got rv=%b raddr=%h required 1/%h",
               vsi_raddr_valid, vsi_raddr, A_BASE);
    end
    finish_job("after_reset");
    check_writes("after_reset", 1, 1'b0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    n_reads        = 0;
    n_done         = 0;
    lat            = 1;
    vsi_reset_n    = 1'b0;
    vsi_start      = 1'b0;
    vsi_matrix_cnt = '0;
    vsi_acc_mode   = 1'b0;
    test_reset();
    test_identity();
    test_neg128();
    test_acc_identity();
    test_cnt_zero();
    test_second_start();
    test_random();
    test_reset_mid_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_engine.md
GEMM_ENGINE -- requirements
Module: gemm_engine

Interface
REQ-001 SHALL have parameter DIM, default 4, square matrix dimension.
REQ-002 SHALL have parameter ELEM_W, default 8, signed input element width.
REQ-003 SHALL have parameter ACC_W, default 32, signed result element width.
REQ-004 SHALL have parameter BUS_W, default 128, data bus width; legal only when DIM*DIM*ELEM_W == BUS_W and DIM*ACC_W == BUS_W.
REQ-005 SHALL have parameter MCNT_W, default 8, matrix-count width.
REQ-006 SHALL have parameters A_BASE, B_BASE and C_BASE, defaults 32'h0000_0000, 32'h0001_0000 and 32'h0002_0000, byte base addresses.
REQ-007 SHALL have ports: vsi_clk, input, 1, the only clock; vsi_reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports: vsi_start, input, 1, start pulse; vsi_matrix_cnt, input, MCNT_W, number of A/B pairs; vsi_acc_mode, input, 1, 0 = per-pair result, 1 = one summed result; vsi_done, output, 1, completion pulse.
REQ-009 SHALL have read ports: vsi_raddr_valid, output, 1; vsi_raddr, output, 32; vsi_rdata_valid, input, 1; vsi_rdata, input, BUS_W.
REQ-010 SHALL have write ports: vsi_wx_valid, output, 1; vsi_waddr, output, 32; vsi_wdata, output, BUS_W; vsi_wstrobe, output, BUS_W/8.

Function
REQ-011 SHALL pack matrix element (r,c) at rdata bits [(r*DIM+c)*ELEM_W +: ELEM_W]; one beat holds a whole A or B.
REQ-012 SHALL read pair k from A_BASE+k*BUS_W/8 and B_BASE+k*BUS_W/8, k = 0..cnt-1.
REQ-013 SHALL emit C row r as one beat, element c at [c*ACC_W +: ACC_W], at C_BASE+(k*DIM+r)*BUS_W/8; in acc_mode, k = 0.
REQ-014 SHALL compute C[r][c] = sum over i of A[r][i]*B[i][c], signed, wrapping modulo 2^ACC_W.
REQ-015 SHALL in acc_mode=1 sum the products of all pairs into one accumulator and write DIM beats only after the last pair.
REQ-016 SHALL use FSM states IDLE, RD_A, RD_B, WAIT, WR, DONE.
REQ-017 SHALL in IDLE sample vsi_start, vsi_matrix_cnt and vsi_acc_mode together and clear the accumulator and pair counter.
REQ-018 SHALL on start go to RD_A, or to DONE if cnt = 0.
REQ-019 SHALL assert vsi_raddr_valid for exactly one cycle in each of RD_A and RD_B, issuing A then B on consecutive cycles.
REQ-020 SHALL treat vsi_rdata as returned in request order with latency >= 1 cycle and no backpressure.
REQ-021 SHALL capture the first rdata beat as A and the second as B; the beats may arrive in the same states as the requests were issued.
REQ-022 SHALL leave WAIT when both beats are held.
REQ-023 SHALL in WR compute and emit one row per cycle for DIM cycles, with vsi_wx_valid high for each row.
REQ-024 SHALL in acc_mode=1, instead of WR, accumulate and return to RD_A until the last pair, then enter WR.
REQ-025 SHALL after the last pair go WR -> DONE, pulse vsi_done for one cycle, then return to IDLE.
REQ-026 SHALL drive vsi_wstrobe all-ones while vsi_wx_valid is high and zero otherwise.
REQ-027 SHALL ignore vsi_start outside IDLE.
REQ-028 SHALL ignore vsi_rdata_valid in IDLE and DONE.

Reset
REQ-029 SHALL, while vsi_reset_n is low (asynchronous, including mid-operation), force state IDLE, all valid outputs and vsi_done to 0, addresses, wdata and wstrobe to 0, and clear the accumulator and counters.
REQ-030 SHALL accept a start on the first rising edge after reset deasserts.

Structure
REQ-031 SHALL place the state enum, the legality checks and the beat-stride constant (BUS_W/8) in the shared package gemm_pkg.
REQ-032 SHALL implement one output row (DIM signed dot products) in sub-module gemm_row_mac, instantiated once.

Verification
REQ-033 SHALL cover: defaults, cnt=1, acc_mode=0, A=identity, B element(r,c)=r*4+c -> 4 writes at 0x20000..0x20030, row r = {r*4+3, r*4+2, r*4+1, r*4}, then a done pulse.
REQ-034 SHALL cover: all A and B elements = -128 -> every C element = 65536.
REQ-035 SHALL cover: cnt=3, acc_mode=1, each pair A=B=identity -> exactly 4 writes starting at 0x20000, diagonal = 3 and off-diagonal = 0.
REQ-036 SHALL cover: cnt=0 -> no read or write transactions, and vsi_done high 2 cycles after start.
REQ-037 SHALL cover: cnt=2 with rdata latency 5 and a second start during WAIT -> the second start is ignored and exactly 8 writes occur.
REQ-038 SHALL cover: reset asserted during WR -> outputs are 0 immediately, and a later start with cnt=1 produces a correct result.
